// File: rtl/pipe_ctrl_pkg.sv
// Shared types, state encodings and defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_BUSY = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam int DEF_FLUSH_CYCLES = 2;
    localparam int DEF_MDU_TIMEOUT  = 64;
    localparam int CNT_W            = 32;
    localparam int CYC_W            = 8;

    // Per-cycle pipeline control decode, produced combinationally from state + inputs.
    typedef struct packed {
        logic stall_fetch;
        logic stall_decode;
        logic bubble_ex;
        logic flush_fd;
        logic mdu_start;
        logic pc_redirect_valid;
    } ctl_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard comparator between decode sources and an in-flight load in execute.
module hazard_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  dec_valid,
    input  logic                  dec_uses_rs1,
    input  logic                  dec_uses_rs2,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = dec_uses_rs1 && (dec_rs1 == ex_rd);
    assign rs2_hit = dec_uses_rs2 && (dec_rs2 == ex_rd);

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = dec_valid && ex_valid && ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, MDU busy stalls with timeout, branch redirect flush.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,  // 1..15
    parameter int MDU_TIMEOUT  = DEF_MDU_TIMEOUT    // 2..255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid,
    input  logic                  dec_uses_rs1,
    input  logic                  dec_uses_rs2,
    input  logic                  dec_is_mdu,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  br_taken,
    input  logic [DATA_WIDTH-1:0] br_target,
    input  logic                  mdu_done,
    output logic                  stall_fetch,
    output logic                  stall_decode,
    output logic                  bubble_ex,
    output logic                  flush_fd,
    output logic                  mdu_start,
    output logic                  pc_redirect_valid,
    output logic                  mdu_err,
    output logic [DATA_WIDTH-1:0] pc_redirect,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count,
    output logic [1:0]            state
);

    state_t           st_q;
    logic [CYC_W-1:0] cyc_cnt;
    logic             load_use;
    logic             br_evt;
    logic             mdu_issue;
    ctl_t             ctl;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .dec_valid    (dec_valid),
        .dec_uses_rs1 (dec_uses_rs1),
        .dec_uses_rs2 (dec_uses_rs2),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .load_use     (load_use)
    );

    // Mealy decode: control reacts in the same cycle the hazard is seen.
    always_comb begin
        ctl       = '0;
        br_evt    = 1'b0;
        mdu_issue = 1'b0;
        case (st_q)
            ST_RUN: begin
                if (br_taken) begin
                    ctl.flush_fd  = 1'b1;
                    ctl.bubble_ex = 1'b1;
                    br_evt        = 1'b1;
                end else if (load_use) begin
                    ctl.stall_fetch  = 1'b1;
                    ctl.stall_decode = 1'b1;
                    ctl.bubble_ex    = 1'b1;
                end else if (dec_valid && dec_is_mdu) begin
                    ctl.mdu_start    = 1'b1;
                    ctl.stall_fetch  = 1'b1;
                    ctl.stall_decode = 1'b1;
                    mdu_issue        = 1'b1;
                end
            end
            ST_MDU_BUSY: begin
                if (!mdu_done) begin
                    ctl.stall_fetch  = 1'b1;
                    ctl.stall_decode = 1'b1;
                    ctl.bubble_ex    = 1'b1;
                end
            end
            ST_REDIRECT: begin
                ctl.flush_fd          = 1'b1;
                ctl.bubble_ex         = 1'b1;
                ctl.pc_redirect_valid = (cyc_cnt == '0);
            end
            default: ;
        endcase
    end

    // cyc_cnt is shared: MDU timeout age in MDU_BUSY, flush cycle index in REDIRECT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= ST_RUN;
            cyc_cnt     <= '0;
            pc_redirect <= '0;
            stall_count <= '0;
            flush_count <= '0;
            mdu_err     <= 1'b0;
        end else begin
            if (ctl.stall_decode) stall_count <= sat_inc(stall_count);
            case (st_q)
                ST_RUN: begin
                    if (br_evt) begin
                        st_q        <= ST_REDIRECT;
                        pc_redirect <= br_target;
                        flush_count <= sat_inc(flush_count);
                        cyc_cnt     <= '0;
                    end else if (mdu_issue) begin
                        st_q    <= ST_MDU_BUSY;
                        cyc_cnt <= '0;
                    end
                end
                ST_MDU_BUSY: begin
                    if (mdu_done) begin
                        st_q <= ST_RUN;
                    end else if (cyc_cnt == CYC_W'(MDU_TIMEOUT - 1)) begin
                        mdu_err <= 1'b1;
                        st_q    <= ST_RUN;
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                end
                ST_REDIRECT: begin
                    if (cyc_cnt == CYC_W'(FLUSH_CYCLES - 1)) st_q <= ST_RUN;
                    else cyc_cnt <= cyc_cnt + CYC_W'(1);
                end
                default: st_q <= ST_RUN;
            endcase
        end
    end

    assign stall_fetch       = ctl.stall_fetch;
    assign stall_decode      = ctl.stall_decode;
    assign bubble_ex         = ctl.bubble_ex;
    assign flush_fd          = ctl.flush_fd;
    assign mdu_start         = ctl.mdu_start;
    assign pc_redirect_valid = ctl.pc_redirect_valid;
    assign state             = st_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench with a per-cycle behavioural model of the hazard controller.
module tb_pipeline_hazard_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int MDU_TIMEOUT  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_uses_rs1, dec_uses_rs2, dec_is_mdu;
    logic [4:0]  dec_rs1, dec_rs2, ex_rd;
    logic        ex_valid, ex_mem_read, br_taken, mdu_done;
    logic [31:0] br_target;
    logic        stall_fetch, stall_decode, bubble_ex, flush_fd, mdu_start, pc_redirect_valid, mdu_err;
    logic [31:0] pc_redirect, stall_count, flush_count;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;

    pipeline_hazard_ctrl #(
        .DATA_WIDTH   (32),
        .REG_ADDR_W   (5),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .MDU_TIMEOUT  (MDU_TIMEOUT)
    ) dut (
        .clk (clk), .rst (rst),
        .dec_valid (dec_valid), .dec_uses_rs1 (dec_uses_rs1), .dec_uses_rs2 (dec_uses_rs2),
        .dec_is_mdu (dec_is_mdu), .dec_rs1 (dec_rs1), .dec_rs2 (dec_rs2),
        .ex_valid (ex_valid), .ex_mem_read (ex_mem_read), .ex_rd (ex_rd),
        .br_taken (br_taken), .br_target (br_target), .mdu_done (mdu_done),
        .stall_fetch (stall_fetch), .stall_decode (stall_decode), .bubble_ex (bubble_ex),
        .flush_fd (flush_fd), .mdu_start (mdu_start), .pc_redirect_valid (pc_redirect_valid),
        .mdu_err (mdu_err), .pc_redirect (pc_redirect), .stall_count (stall_count),
        .flush_count (flush_count), .state (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model: remaining flush cycles, MDU age, running totals ----
    int          m_redir_left = 0;
    bit          m_mdu_active = 1'b0;
    int          m_mdu_age    = 0;
    bit          m_err        = 1'b0;
    logic [31:0] m_pc         = '0;
    logic [31:0] m_stall      = '0;
    logic [31:0] m_flush      = '0;
    logic        lu, e_sf, e_sd, e_bx, e_ff, e_ms, e_prv;
    logic [1:0]  e_state;

    always @(negedge clk) begin
        if (!rst) begin
            m_redir_left = 0; m_mdu_active = 1'b0; m_mdu_age = 0; m_err = 1'b0;
            m_pc = '0; m_stall = '0; m_flush = '0;
        end
        lu = dec_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
             ((dec_uses_rs1 && dec_rs1 == ex_rd) || (dec_uses_rs2 && dec_rs2 == ex_rd));
        {e_sf, e_sd, e_bx, e_ff, e_ms, e_prv} = 6'b0;
        if (m_redir_left > 0) begin
            e_ff = 1'b1; e_bx = 1'b1; e_prv = (m_redir_left == FLUSH_CYCLES);
        end else if (m_mdu_active) begin
            if (!mdu_done) {e_sf, e_sd, e_bx} = 3'b111;
        end else if (br_taken) begin
            e_ff = 1'b1; e_bx = 1'b1;
        end else if (lu) begin
            {e_sf, e_sd, e_bx} = 3'b111;
        end else if (dec_valid && dec_is_mdu) begin
            {e_ms, e_sf, e_sd} = 3'b111;
        end
        e_state = (m_redir_left > 0) ? 2'd2 : (m_mdu_active ? 2'd1 : 2'd0);

        chk("ctl_vec", 32'({stall_fetch, stall_decode, bubble_ex, flush_fd, mdu_start, pc_redirect_valid}),
            32'({e_sf, e_sd, e_bx, e_ff, e_ms, e_prv}));
        chk("state", 32'(state), 32'(e_state));
        chk("pc_redirect", pc_redirect, m_pc);
        chk("stall_count", stall_count, m_stall);
        chk("flush_count", flush_count, m_flush);
        chk("mdu_err", 32'(mdu_err), 32'(m_err));

        // advance to the values expected after the next rising edge
        if (rst) begin
            if (m_redir_left > 0) begin
                m_redir_left--;
            end else if (m_mdu_active) begin
                m_mdu_age++;
                if (mdu_done) m_mdu_active = 1'b0;
                else if (m_mdu_age == MDU_TIMEOUT) begin
                    m_err = 1'b1; m_mdu_active = 1'b0;
                end
            end else if (br_taken) begin
                m_redir_left = FLUSH_CYCLES; m_pc = br_target;
                if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
            end else if (!lu && dec_valid && dec_is_mdu) begin
                m_mdu_active = 1'b1; m_mdu_age = 0;
            end
            if (e_sd && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        end
    end

    // ---- directed stimulus with literal expectations ----
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dec_valid = 0; dec_uses_rs1 = 0; dec_uses_rs2 = 0; dec_is_mdu = 0;
        dec_rs1 = 0; dec_rs2 = 0; ex_valid = 0; ex_mem_read = 0; ex_rd = 0;
        br_taken = 0; br_target = 0; mdu_done = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs2);
        ex_valid = 1; ex_mem_read = 1; ex_rd = rd;
        dec_valid = 1; dec_uses_rs2 = 1; dec_rs2 = rs2; dec_uses_rs1 = 1; dec_rs1 = 5'd3;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        step(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_stall_count", stall_count, 32'd0);
        chk("rst_pc", pc_redirect, 32'd0);
        rst = 1'b1;
        step(1);

        // load-use on rs2
        set_load(5'd5, 5'd5);
        #1 chk("lu_stall", 32'({stall_fetch, stall_decode, bubble_ex}), 32'b111);
        step(1);
        clear_inputs();
        #1 chk("lu_count", stall_count, 32'd1);
        chk("lu_state", 32'(state), 32'd0);
        chk("lu_released", 32'(stall_decode), 32'd0);

        // x0 destination, unused rs1 match, non-load: no hazard
        do_reset();
        set_load(5'd0, 5'd0);
        #1 chk("rd0_nostall", 32'(stall_decode), 32'd0);
        step(1);
        set_load(5'd5, 5'd7); dec_uses_rs1 = 0; dec_rs1 = 5'd5;
        #1 chk("unused_rs1", 32'(stall_decode), 32'd0);
        step(1);
        set_load(5'd5, 5'd5); ex_mem_read = 0;
        #1 chk("not_load", 32'(stall_decode), 32'd0);
        step(1);
        clear_inputs();
        #1 chk("rd0_count", stall_count, 32'd0);

        // branch with concurrent load-use
        do_reset();
        set_load(5'd5, 5'd5); br_taken = 1; br_target = 32'h100;
        #1 chk("br_ctl", 32'({stall_fetch, stall_decode, bubble_ex, flush_fd, mdu_start, pc_redirect_valid}), 32'b001100);
        step(1);
        br_taken = 0; dec_is_mdu = 1;
        #1 chk("redir1_ctl", 32'({stall_fetch, stall_decode, bubble_ex, flush_fd, mdu_start, pc_redirect_valid}), 32'b001101);
        chk("redir1_pc", pc_redirect, 32'h100);
        chk("redir1_state", 32'(state), 32'd2);
        chk("redir1_flush", flush_count, 32'd1);
        step(1);
        br_taken = 1; br_target = 32'h200;
        #1 chk("redir2_ctl", 32'({stall_fetch, stall_decode, bubble_ex, flush_fd, mdu_start, pc_redirect_valid}), 32'b001100);
        step(1);
        br_taken = 0; dec_is_mdu = 0;
        #1 chk("redir_done_state", 32'(state), 32'd0);
        chk("redir_done_pc", pc_redirect, 32'h100);
        chk("redir_done_flush", flush_count, 32'd1);
        chk("redir_done_lu", 32'({stall_fetch, stall_decode, bubble_ex}), 32'b111);
        step(1);
        clear_inputs();

        // MDU completing on the 11th busy cycle
        do_reset();
        dec_valid = 1; dec_is_mdu = 1;
        #1 chk("mdu_issue", 32'({mdu_start, stall_fetch, stall_decode, bubble_ex}), 32'b1110);
        step(1);
        clear_inputs();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin br_taken = 1; br_target = 32'hDEAD; end
            #1 chk("mdu_busy", 32'({mdu_start, stall_fetch, stall_decode, bubble_ex}), 32'b0111);
            step(1);
            br_taken = 0;
        end
        mdu_done = 1;
        #1 chk("mdu_done_rel", 32'({stall_fetch, stall_decode, bubble_ex}), 32'b000);
        step(1);
        mdu_done = 0;
        #1 chk("mdu_count", stall_count, 32'd11);
        chk("mdu_state", 32'(state), 32'd0);
        chk("mdu_br_ignored", flush_count, 32'd0);

        // MDU timeout
        do_reset();
        dec_valid = 1; dec_is_mdu = 1;
        step(1);
        clear_inputs();
        step(63);
        chk("to_last_state", 32'(state), 32'd1);
        chk("to_last_err", 32'(mdu_err), 32'd0);
        step(1);
        chk("to_state", 32'(state), 32'd0);
        chk("to_err", 32'(mdu_err), 32'd1);
        dec_valid = 1; dec_is_mdu = 1;
        step(1);
        clear_inputs(); mdu_done = 1;
        step(1);
        mdu_done = 0;
        step(3);
        chk("to_err_sticky", 32'(mdu_err), 32'd1);
        do_reset();
        chk("to_err_cleared", 32'(mdu_err), 32'd0);

        // reset during the first redirect cycle
        br_taken = 1; br_target = 32'h300;
        step(1);
        br_taken = 0;
        #1 chk("rr_prv", 32'(pc_redirect_valid), 32'd1);
        rst = 1'b0;
        #1 chk("rr_state", 32'(state), 32'd0);
        chk("rr_pc", pc_redirect, 32'd0);
        chk("rr_ctl", 32'({stall_fetch, stall_decode, bubble_ex, flush_fd, mdu_start, pc_redirect_valid}), 32'd0);
        step(1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("rr_no_residual", 32'({flush_fd, pc_redirect_valid}), 32'd0);
        end

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
